countdown_timer_16bits: RTL and testbench

Loadable 16-bit down-counter that is the counting-down counterpart of the up-counting counter_16bits. It serves as the alarm/snooze countdown in the alarm clock. A value is loaded, decremented once every PRESCALE clocks while running, and the block raises a one-cycle Expired pulse and a held Ring level at zero. Optional auto-reload supports repeating snooze intervals.

---
 rtl/countdown_timer_16bits.sv | 124 ++++++++++++
 tb/tb_countdown_timer_16bits.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/countdown_timer_16bits.sv
// Loadable down-counter with prescaled decrement, one-cycle Expired pulse,
// held Ring level and optional auto-reload on expiry.
module countdown_timer_16bits #(
   parameter int unsigned WIDTH    = 16,
   parameter int unsigned PRESCALE = 1
) (
   input  logic             Clk,
   input  logic             Clr,
   input  logic             Load,
   input  logic [WIDTH-1:0] LOAD_VALUE,
   input  logic             Start,
   input  logic             Pause,
   input  logic             Ack,
   input  logic             AutoReload,
   output logic [WIDTH-1:0] COUNT,
   output logic             Busy,
   output logic             Expired,
   output logic             Ring
);

   localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0]    PS_MAX = PW'(PRESCALE - 1);
   localparam logic [WIDTH-1:0] ONE    = WIDTH'(1);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_RUN     = 2'd1;
   localparam logic [1:0] S_PAUSE   = 2'd2;
   localparam logic [1:0] S_EXPIRED = 2'd3;

   logic [1:0]       state, state_n;
   logic [WIDTH-1:0] count_n;
   logic [WIDTH-1:0] reload, reload_n;
   logic [PW-1:0]    pre, pre_n;
   logic             expired_n;
   logic             ring_n;

   always_comb begin
      state_n   = state;
      count_n   = COUNT;
      reload_n  = reload;
      pre_n     = pre;
      expired_n = 1'b0;
      ring_n    = Ring;

      if (Load) begin
         count_n  = LOAD_VALUE;
         reload_n = LOAD_VALUE;
         pre_n    = '0;
         ring_n   = 1'b0;
         state_n  = S_IDLE;
      end else begin
         case (state)
            S_IDLE: begin
               if (Ack) begin
                  ring_n = 1'b0;
               end else if (Start && !Pause && (COUNT != '0)) begin
                  state_n = S_RUN;
                  pre_n   = '0;
               end
            end
            S_RUN: begin
               // Ack only clears Ring; counting continues, and an expiry on
               // the same edge re-sets Ring below.
               if (Ack) begin
                  ring_n = 1'b0;
               end
               if (!Ack && Pause) begin
                  state_n = S_PAUSE;
               end else if (pre != PS_MAX) begin
                  pre_n = pre + PW'(1);
               end else begin
                  pre_n = '0;
                  if (COUNT > ONE) begin
                     count_n = COUNT - ONE;
                  end else if (COUNT == ONE) begin
                     expired_n = 1'b1;
                     ring_n    = 1'b1;
                     if (AutoReload && (reload != '0)) begin
                        count_n = reload;
                     end else begin
                        count_n = '0;
                        state_n = S_EXPIRED;
                     end
                  end
               end
            end
            S_PAUSE: begin
               if (Ack) begin
                  ring_n = 1'b0;
               end else if (!Pause && Start) begin
                  state_n = S_RUN;
               end
            end
            default: begin
               if (Ack) begin
                  ring_n  = 1'b0;
                  state_n = S_IDLE;
               end
            end
         endcase
      end
   end

   always_ff @(posedge Clk) begin
      if (Clr) begin
         state   <= S_IDLE;
         COUNT   <= '0;
         reload  <= '0;
         pre     <= '0;
         Busy    <= 1'b0;
         Expired <= 1'b0;
         Ring    <= 1'b0;
      end else begin
         state   <= state_n;
         COUNT   <= count_n;
         reload  <= reload_n;
         pre     <= pre_n;
         Busy    <= (state_n == S_RUN);
         Expired <= expired_n;
         Ring    <= ring_n;
      end
   end

endmodule

// File: tb/tb_countdown_timer_16bits.sv
// Directed bench for countdown_timer_16bits: one unprescaled and one
// PRESCALE=4 instance driven from the same inputs.
module tb_countdown_timer_16bits;

   logic        Clk = 1'b0;
   logic        Clr, Load, Start, Pause, Ack, AutoReload;
   logic [15:0] LOAD_VALUE;
   logic [15:0] count1, count4;
   logic        busy1, busy4, exp1, exp4, ring1, ring4;

   int n_cmp = 0;
   int n_err = 0;

   always #5 Clk = ~Clk;

   countdown_timer_16bits #(.WIDTH(16), .PRESCALE(1)) dut1 (
      .Clk(Clk), .Clr(Clr), .Load(Load), .LOAD_VALUE(LOAD_VALUE),
      .Start(Start), .Pause(Pause), .Ack(Ack), .AutoReload(AutoReload),
      .COUNT(count1), .Busy(busy1), .Expired(exp1), .Ring(ring1)
   );

   countdown_timer_16bits #(.WIDTH(16), .PRESCALE(4)) dut4 (
      .Clk(Clk), .Clr(Clr), .Load(Load), .LOAD_VALUE(LOAD_VALUE),
      .Start(Start), .Pause(Pause), .Ack(Ack), .AutoReload(AutoReload),
      .COUNT(count4), .Busy(busy4), .Expired(exp4), .Ring(ring4)
   );

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
      n_cmp++;
      assert (obs === exp_v) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   // chk1: COUNT, Busy, Expired, Ring of the unprescaled instance
   task automatic chk1(input string tag, input logic [15:0] c, input logic b, input logic e, input logic r);
      chk({tag, ".count"},   count1, c);
      chk({tag, ".busy"},    16'(busy1), 16'(b));
      chk({tag, ".expired"}, 16'(exp1),  16'(e));
      chk({tag, ".ring"},    16'(ring1), 16'(r));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      Clr = 1'b1; Load = 1'b0; Start = 1'b0; Pause = 1'b0; Ack = 1'b0;
      AutoReload = 1'b0; LOAD_VALUE = '0;
      tick(); tick();
      chk1("por", 16'h0000, 1'b0, 1'b0, 1'b0);
      Clr = 1'b0;

      // reset mid-RUN
      LOAD_VALUE = 16'h0010; Load = 1'b1; tick(); Load = 1'b0;
      Start = 1'b1; tick(); Start = 1'b0;
      chk1("rst_start", 16'h0010, 1'b1, 1'b0, 1'b0);
      tick();
      chk1("rst_run", 16'h000F, 1'b1, 1'b0, 1'b0);
      Clr = 1'b1; tick(); tick(); Clr = 1'b0;
      chk1("rst_clr", 16'h0000, 1'b0, 1'b0, 1'b0);
      chk("rst_clr4.count", count4, 16'h0000);

      // basic countdown
      LOAD_VALUE = 16'h0003; Load = 1'b1; tick(); Load = 1'b0;
      chk1("basic_load", 16'h0003, 1'b0, 1'b0, 1'b0);
      Start = 1'b1; tick(); Start = 1'b0;
      chk1("basic_k", 16'h0003, 1'b1, 1'b0, 1'b0);
      tick(); chk1("basic_2", 16'h0002, 1'b1, 1'b0, 1'b0);
      tick(); chk1("basic_1", 16'h0001, 1'b1, 1'b0, 1'b0);
      tick(); chk1("basic_0", 16'h0000, 1'b0, 1'b1, 1'b0 | 1'b1);
      tick(); chk1("basic_hold", 16'h0000, 1'b0, 1'b0, 1'b1);
      Ack = 1'b1; tick(); Ack = 1'b0;
      chk1("basic_ack", 16'h0000, 1'b0, 1'b0, 1'b0);

      // prescale 4 on dut4
      LOAD_VALUE = 16'h0002; Load = 1'b1; tick(); Load = 1'b0;
      Start = 1'b1; tick(); Start = 1'b0;
      chk("ps_k.count", count4, 16'h0002);
      chk("ps_k.busy", 16'(busy4), 16'h0001);
      for (int i = 1; i <= 8; i++) begin
         tick();
         chk($sformatf("ps_%0d.count", i), count4, (i < 4) ? 16'h0002 : (i < 8) ? 16'h0001 : 16'h0000);
         chk($sformatf("ps_%0d.expired", i), 16'(exp4), (i == 8) ? 16'h0001 : 16'h0000);
      end
      tick();
      chk("ps_after.expired", 16'(exp4), 16'h0000);
      chk("ps_after.ring", 16'(ring4), 16'h0001);
      chk("ps_after.busy", 16'(busy4), 16'h0000);
      Ack = 1'b1; tick(); Ack = 1'b0;
      chk("ps_ack.ring", 16'(ring4), 16'h0000);

      // pause / resume
      LOAD_VALUE = 16'h0005; Load = 1'b1; tick(); Load = 1'b0;
      Start = 1'b1; tick(); Start = 1'b0;
      chk1("pr_k", 16'h0005, 1'b1, 1'b0, 1'b0);
      tick(); tick();
      chk1("pr_2ticks", 16'h0003, 1'b1, 1'b0, 1'b0);
      Pause = 1'b1; tick(); Pause = 1'b0;
      chk1("pr_pause", 16'h0003, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) tick();
      chk1("pr_frozen", 16'h0003, 1'b0, 1'b0, 1'b0);
      Start = 1'b1; Pause = 1'b1; tick(); Pause = 1'b0;
      chk1("pr_both", 16'h0003, 1'b0, 1'b0, 1'b0);
      tick(); Start = 1'b0;
      chk1("pr_resume", 16'h0003, 1'b1, 1'b0, 1'b0);
      tick(); chk1("pr_2", 16'h0002, 1'b1, 1'b0, 1'b0);
      tick(); chk1("pr_1", 16'h0001, 1'b1, 1'b0, 1'b0);
      tick(); chk1("pr_0", 16'h0000, 1'b0, 1'b1, 1'b1);
      Ack = 1'b1; tick(); Ack = 1'b0;

      // auto-reload
      AutoReload = 1'b1;
      LOAD_VALUE = 16'h0002; Load = 1'b1; tick(); Load = 1'b0;
      Start = 1'b1; tick(); Start = 1'b0;
      chk1("ar_k", 16'h0002, 1'b1, 1'b0, 1'b0);
      tick(); chk1("ar_1a", 16'h0001, 1'b1, 1'b0, 1'b0);
      tick(); chk1("ar_2a", 16'h0002, 1'b1, 1'b1, 1'b1);
      Ack = 1'b1; tick(); Ack = 1'b0;
      chk1("ar_ack", 16'h0001, 1'b1, 1'b0, 1'b0);
      tick(); chk1("ar_2b", 16'h0002, 1'b1, 1'b1, 1'b1);
      Ack = 1'b1; tick();
      chk1("ar_1c", 16'h0001, 1'b1, 1'b0, 1'b0);
      tick(); Ack = 1'b0;
      chk1("ar_ack_expiry", 16'h0002, 1'b1, 1'b1, 1'b1);
      AutoReload = 1'b0;
      LOAD_VALUE = 16'h0000; Load = 1'b1; tick(); Load = 1'b0;
      chk1("ar_load0", 16'h0000, 1'b0, 1'b0, 1'b0);

      // corner cases
      Start = 1'b1; tick(); Start = 1'b0;
      chk1("cc_start0", 16'h0000, 1'b0, 1'b0, 1'b0);
      LOAD_VALUE = 16'h0001; Load = 1'b1; tick(); Load = 1'b0;
      Start = 1'b1; tick(); Start = 1'b0;
      chk1("cc_k", 16'h0001, 1'b1, 1'b0, 1'b0);
      tick(); chk1("cc_exp", 16'h0000, 1'b0, 1'b1, 1'b1);
      tick(); chk1("cc_nowrap", 16'h0000, 1'b0, 1'b0, 1'b1);
      Start = 1'b1; tick(); Start = 1'b0;
      chk1("cc_exp_start", 16'h0000, 1'b0, 1'b0, 1'b1);
      LOAD_VALUE = 16'hFFFF; Load = 1'b1; tick(); Load = 1'b0;
      chk1("cc_loadffff", 16'hFFFF, 1'b0, 1'b0, 1'b0);
      Start = 1'b1; tick(); Start = 1'b0;
      chk1("cc_ffff_k", 16'hFFFF, 1'b1, 1'b0, 1'b0);
      tick(); chk1("cc_fffe", 16'hFFFE, 1'b1, 1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
